ram_fifo_ctrl: RTL and testbench
================================

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5: RAM address width; RAM depth is 2**ADDR_WIDTH.
REQ-003 clk_i  input  1  single clock for all logic.
REQ-004 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 wr_data_i  input  DATA_WIDTH  write word.
REQ-006 wr_i  input  1  write request; the word is accepted when wr_i=1 and full_o=0.
REQ-007 full_o  output  1  RAM holds 2**ADDR_WIDTH unfetched words.
REQ-008 rd_data_o  output  DATA_WIDTH  head word (show-ahead).
REQ-009 rd_valid_o  output  1  rd_data_o is valid.
REQ-010 rd_ready_i  input  1  consumer pop; a pop occurs when rd_valid_o=1 and rd_ready_i=1.
REQ-011 used_o  output  ADDR_WIDTH+2  total words held (RAM + in-flight + output buffer).
REQ-012 ram_wr_addr_o  output  ADDR_WIDTH  RAM write address.
REQ-013 ram_wr_data_o  output  DATA_WIDTH  RAM write data.
REQ-014 ram_wr_o  output  1  RAM write strobe.
REQ-015 ram_rd_addr_o  output  ADDR_WIDTH  RAM read address.
REQ-016 ram_rd_o  output  1  RAM read enable; the RAM registers data one cycle later and holds it while ram_rd_o=0.
REQ-017 ram_rd_data_i  input  DATA_WIDTH  RAM registered read data.

Function
REQ-018 The write side shall be combinational.
- ram_wr_o = wr_i & ~full_o.
- ram_wr_addr_o = wr_ptr.
- ram_wr_data_o = wr_data_i.
- wr_ptr increments modulo 2**ADDR_WIDTH on each accepted write.
REQ-019 ram_cnt (words in RAM not yet fetched, 0..2**ADDR_WIDTH) shall be updated as +1 on an accepted write, -1 on an issued read, unchanged when both or neither occur in the same cycle.
REQ-020 full_o shall equal (ram_cnt == 2**ADDR_WIDTH), derived from registered state only.
REQ-021 Read issue: ram_rd_o = (ram_cnt != 0) & (buf_cnt + pend - pop < 2).
- ram_rd_addr_o = rd_ptr.
- rd_ptr increments modulo 2**ADDR_WIDTH per issue.
REQ-022 pend shall be a flag set to the value of ram_rd_o at each clock edge.
REQ-023 While pend=1, ram_rd_data_i shall be written into a 2-entry output buffer (head, skid) at the end of that cycle.
REQ-024 Output buffer rules:
- rd_data_o/rd_valid_o come from the head entry.
- A pop advances skid to head.
- Simultaneous pop and landing is allowed with no loss or reorder.
- buf_cnt never exceeds 2.
REQ-025 Sustained throughput shall be one word per cycle when the RAM is non-empty and rd_ready_i=1.
REQ-026 First-word latency: write accepted in cycle N -> ram_rd_o=1 in cycle N+1 -> rd_valid_o=1 in cycle N+3.
REQ-027 used_o = ram_cnt + pend + buf_cnt, registered; maximum value 2**ADDR_WIDTH+2.
REQ-028 Write while full_o=1 shall be dropped: no RAM write, no pointer or count change.
REQ-029 Pop while rd_valid_o=0 shall be ignored.
REQ-030 Data order out shall equal accepted write order across pointer wrap-around.
REQ-031 A write to address X and a read issue from address X in the same cycle cannot occur, because full_o blocks writes when wr_ptr==rd_ptr with ram_cnt=2**ADDR_WIDTH.

Reset
REQ-032 rst_n_i=0 shall asynchronously clear wr_ptr, rd_ptr, ram_cnt, pend, buf_cnt and used_o to 0.
REQ-033 During reset:
- rd_valid_o=0, full_o=0, ram_rd_o=0, ram_wr_o=0.
- rd_data_o=0.
REQ-034 Reset mid-operation shall discard all held and in-flight words; the first write after release lands at RAM address 0.
REQ-035 The first accepted write shall occur no earlier than the first clock edge after rst_n_i rises.

Verification
REQ-036 Single word: write 0xA5 at cycle 0, rd_ready_i=0 -> rd_valid_o=1 with 0xA5 from cycle 3, used_o=1 held.
REQ-037 Fill (ADDR_WIDTH=5), rd_ready_i=0: write 0..35 -> first 34 accepted, full_o=1 after word 34 (32 in RAM + 2 buffered), used_o=34, writes 34,35 dropped.
REQ-038 Streaming: continuous writes with rd_ready_i=1 -> after initial latency rd_valid_o stays 1 each cycle, outputs in order, used_o steady.
REQ-039 Wrap: 100 words through with random rd_ready_i -> output sequence equals input sequence, pointers wrap past 31 with no loss.
REQ-040 Backpressure toggle: rd_ready_i alternating 1/0 with buffer full -> no duplicate or dropped word; buf_cnt stays <= 2.
REQ-041 Reset mid-stream: assert rst_n_i with used_o=10 -> rd_valid_o=0 and used_o=0 immediately; a post-reset write of 0x3C appears 3 cycles later.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external synchronous RAM, with a two-entry
// show-ahead output buffer that hides the RAM's one-cycle read latency.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  wr_i,
    output logic                  full_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [ADDR_WIDTH+1:0] used_o,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wr_data_o,
    output logic                  ram_wr_o,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
    output logic                  ram_rd_o,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic                  pend_q, pend_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic [ADDR_WIDTH+1:0] used_q, used_d;

    logic                  full_s;
    logic                  wr_acc_s;
    logic                  rd_valid_s;
    logic                  pop_s;
    logic                  rd_issue_s;
    logic [2:0]            occ_s;

    // Handshakes and read-issue decision; rst_n_i gates writes so none land during reset.
    always_comb begin
        full_s     = (ram_cnt_q == DEPTH_C);
        wr_acc_s   = wr_i & ~full_s & rst_n_i;
        rd_valid_s = (buf_cnt_q != 2'd0);
        pop_s      = rd_valid_s & rd_ready_i;
        occ_s      = {1'b0, buf_cnt_q} + {2'b00, pend_q} - {2'b00, pop_s};
        rd_issue_s = (ram_cnt_q != {(ADDR_WIDTH+1){1'b0}}) & (occ_s < 3'd2);
    end

    // Pointer, RAM occupancy and in-flight flag next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pend_d   = rd_issue_s;
        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_issue_s) begin
            rd_ptr_d = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_acc_s, rd_issue_s})
            2'b10:   ram_cnt_d = ram_cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            2'b01:   ram_cnt_d = ram_cnt_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
            default: ram_cnt_d = ram_cnt_q;
        endcase
    end

    // Output buffer: a landing word goes to the first free slot after any pop.
    always_comb begin
        head_d    = head_q;
        skid_d    = skid_q;
        buf_cnt_d = buf_cnt_q;
        case ({pop_s, pend_q})
            2'b11: begin
                if (buf_cnt_q == 2'd2) begin
                    head_d = skid_q;
                    skid_d = ram_rd_data_i;
                end else begin
                    head_d = ram_rd_data_i;
                end
            end
            2'b10: begin
                head_d    = skid_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b01: begin
                if (buf_cnt_q == 2'd0) begin
                    head_d    = ram_rd_data_i;
                    buf_cnt_d = 2'd1;
                end else if (buf_cnt_q == 2'd1) begin
                    skid_d    = ram_rd_data_i;
                    buf_cnt_d = 2'd2;
                end else begin
                    buf_cnt_d = buf_cnt_q;
                end
            end
            default: buf_cnt_d = buf_cnt_q;
        endcase
        used_d = (ADDR_WIDTH+2)'(ram_cnt_d) + (ADDR_WIDTH+2)'(pend_d)
               + (ADDR_WIDTH+2)'(buf_cnt_d);
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q  <= {ADDR_WIDTH{1'b0}};
            rd_ptr_q  <= {ADDR_WIDTH{1'b0}};
            ram_cnt_q <= {(ADDR_WIDTH+1){1'b0}};
            pend_q    <= 1'b0;
            buf_cnt_q <= 2'd0;
            head_q    <= {DATA_WIDTH{1'b0}};
            skid_q    <= {DATA_WIDTH{1'b0}};
            used_q    <= {(ADDR_WIDTH+2){1'b0}};
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            pend_q    <= pend_d;
            buf_cnt_q <= buf_cnt_d;
            head_q    <= head_d;
            skid_q    <= skid_d;
            used_q    <= used_d;
        end
    end

    assign full_o        = full_s;
    assign ram_wr_o      = wr_acc_s;
    assign ram_wr_addr_o = wr_ptr_q;
    assign ram_wr_data_o = wr_data_i;
    assign ram_rd_o      = rd_issue_s;
    assign ram_rd_addr_o = rd_ptr_q;
    assign rd_valid_o    = rd_valid_s;
    assign rd_data_o     = head_q;
    assign used_o        = used_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: hand-derived vector table, directed corner cases,
// and random traffic against a queue-based reference model.
module tb_ram_fifo_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [7:0] wr_data_i;
    logic       wr_i;
    logic       full_o;
    logic [7:0] rd_data_o;
    logic       rd_valid_o;
    logic       rd_ready_i;
    logic [6:0] used_o;
    logic [4:0] ram_wr_addr_o;
    logic [7:0] ram_wr_data_o;
    logic       ram_wr_o;
    logic [4:0] ram_rd_addr_o;
    logic       ram_rd_o;
    logic [7:0] ram_rd_data_i;

    always #5 clk_i = ~clk_i;

    ram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .wr_data_i(wr_data_i), .wr_i(wr_i),
        .full_o(full_o), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .rd_ready_i(rd_ready_i), .used_o(used_o), .ram_wr_addr_o(ram_wr_addr_o),
        .ram_wr_data_o(ram_wr_data_o), .ram_wr_o(ram_wr_o),
        .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_o(ram_rd_o),
        .ram_rd_data_i(ram_rd_data_i)
    );

    // Synchronous RAM: registered read data, held while not reading.
    logic [7:0] mem [32];
    logic [7:0] ram_q;
    int dut_wr_cnt;
    always @(posedge clk_i) begin
        if (ram_wr_o) mem[ram_wr_addr_o] <= ram_wr_data_o;
        if (ram_rd_o) ram_q <= mem[ram_rd_addr_o];
    end
    always @(posedge clk_i) if (ram_wr_o) dut_wr_cnt <= dut_wr_cnt + 1;
    assign ram_rd_data_i = ram_q;

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference model: all held words in order, plus occupancy bookkeeping.
    logic [7:0] held[$];
    int ram_n, pend_m, buf_n, wptr, rptr;

    task automatic do_reset();
        rst_n_i = 1'b0;
        wr_i = 1'b1;
        rd_ready_i = 1'b1;
        wr_data_i = 8'h77;
        #1;
        chk("rst_valid", rd_valid_o, 0);
        chk("rst_used", used_o, 0);
        chk("rst_full", full_o, 0);
        chk("rst_ram_rd", ram_rd_o, 0);
        chk("rst_ram_wr", ram_wr_o, 0);
        chk("rst_data", rd_data_o, 0);
        held.delete();
        ram_n = 0; pend_m = 0; buf_n = 0; wptr = 0; rptr = 0;
        @(posedge clk_i);
        dut_wr_cnt = 0;
        @(posedge clk_i);
        #1;
        wr_i = 1'b0;
        rd_ready_i = 1'b0;
        rst_n_i = 1'b1;
    endtask

    task automatic cycle(input logic wr, input logic [7:0] d, input logic rdy);
        bit full, acc, valid, pop, issue;
        wr_i = wr; wr_data_i = d; rd_ready_i = rdy;
        #4;
        full  = (ram_n == 32);
        acc   = wr && !full;
        valid = (buf_n > 0);
        pop   = valid && rdy;
        issue = (ram_n != 0) && (buf_n + pend_m - int'(pop) < 2);
        chk("full", full_o, int'(full));
        chk("ram_wr", ram_wr_o, int'(acc));
        if (acc) chk("wr_addr", ram_wr_addr_o, wptr);
        chk("ram_rd", ram_rd_o, int'(issue));
        if (issue) chk("rd_addr", ram_rd_addr_o, rptr);
        chk("valid", rd_valid_o, int'(valid));
        if (valid) chk("data", rd_data_o, held[0]);
        chk("used", used_o, ram_n + pend_m + buf_n);
        if (pop) void'(held.pop_front());
        buf_n  = buf_n + pend_m - int'(pop);
        ram_n  = ram_n + int'(acc) - int'(issue);
        pend_m = int'(issue);
        if (acc) begin
            held.push_back(d);
            wptr = (wptr + 1) % 32;
        end
        if (issue) rptr = (rptr + 1) % 32;
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       rdy;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_used;
    } vec_t;
    vec_t tbl[7];

    initial begin
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 0};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0};

        rst_n_i = 1'b0;
        wr_i = 1'b0; rd_ready_i = 1'b0; wr_data_i = 8'h00;
        dut_wr_cnt = 0;
        #2;
        do_reset();

        // Single word latency table.
        for (int i = 0; i < 7; i++) begin
            wr_i = tbl[i].wr; wr_data_i = tbl[i].data; rd_ready_i = tbl[i].rdy;
            #4;
            chk($sformatf("tbl%0d_valid", i), rd_valid_o, tbl[i].exp_valid);
            if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), rd_data_o, tbl[i].exp_data);
            chk($sformatf("tbl%0d_used", i), used_o, tbl[i].exp_used);
            chk($sformatf("tbl%0d_full", i), full_o, 0);
            @(posedge clk_i);
            #1;
        end

        // Fill with the consumer stalled.
        do_reset();
        for (int i = 0; i < 36; i++) cycle(1'b1, 8'(i), 1'b0);
        #4;
        chk("fill_accepted", dut_wr_cnt, 34);
        chk("fill_full", full_o, 1);
        chk("fill_used", used_o, 34);
        @(posedge clk_i); #1;
        for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b1);
        #4;
        chk("drain_used", used_o, 0);
        @(posedge clk_i); #1;

        // Streaming: after latency the output stays valid every cycle.
        do_reset();
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1, 8'(i + 100), 1'b1);
            if (i >= 3) begin
                chk("stream_valid", rd_valid_o, 1);
            end
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1);

        // Random traffic through pointer wrap.
        do_reset();
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("wrap_enough_words", int'(dut_wr_cnt >= 100), 1);
        chk("wrap_empty", used_o, 0);

        // Backpressure toggling with a full output buffer.
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(i + 50), 1'b0);
        for (int i = 0; i < 60; i++) cycle(1'b1, 8'($urandom), 1'(i % 2));
        for (int i = 0; i < 45; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("bp_empty", used_o, 0);

        // Reset mid-stream with ten words held.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i + 1), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
        #4;
        chk("mid_used_before", used_o, 10);
        do_reset();
        cycle(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b0);
        #4;
        chk("post_rst_valid", rd_valid_o, 1);
        chk("post_rst_data", rd_data_o, 8'h3C);
        chk("post_rst_used", used_o, 1);
        @(posedge clk_i); #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
